// File: rtl/count_job_dispatcher.sv
// count_job_dispatcher: queues countdown jobs in a small FIFO, loads each into the
// down-counter and pulses cmpl as it drains. Optional COUNT_JOB_DISPATCHER_CMPL_CNT_EN adds cmpl_cnt.
module count_job_dispatcher #(
    parameter int unsigned NBITS = 3,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             req_val,
    output logic             req_rdy,
    input  logic [NBITS-1:0] req_cnt,
    output logic             ld,
    output logic [NBITS-1:0] ld_cnt,
    input  logic             done,
    output logic             cmpl,
    output logic             busy,
    output logic [7:0]       cmpl_cnt
);
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = PW + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2
    } state_e;

    state_e           state_q;
    logic [NBITS-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q;
    logic [PW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             push_c;
    logic             pop_c;
    logic             empty_c;
    logic             full_c;

    assign empty_c = (count_q == '0);
    assign full_c  = (count_q == CW'(DEPTH));
    // A full FIFO refuses even while popping: ready depends on registered state only
    assign push_c  = req_val && !full_c;
    assign pop_c   = (state_q == LOAD);

    assign req_rdy = !full_c;
    assign ld      = (state_q == LOAD);
    assign ld_cnt  = (state_q == LOAD) ? mem_q[rd_ptr_q] : '0;
    assign busy    = (state_q != IDLE);
    assign cmpl    = (state_q == RUN) && done;

    // Job FIFO storage and pointers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_c) begin
                mem_q[wr_ptr_q] <= req_cnt;
                wr_ptr_q        <= wr_ptr_q + PW'(1);
            end
            if (pop_c) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            count_q <= count_q + CW'(push_c) - CW'(pop_c);
        end
    end

    // Dispatch sequencer; done is only meaningful once a job has been loaded
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            case (state_q)
                IDLE: if (!empty_c) state_q <= LOAD;
                LOAD: state_q <= RUN;
                RUN: begin
                    if (done) begin
                        state_q <= empty_c ? IDLE : LOAD;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef COUNT_JOB_DISPATCHER_CMPL_CNT_EN
    logic [7:0] cmpl_cnt_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cmpl_cnt_q <= '0;
        end else if (cmpl) begin
            cmpl_cnt_q <= cmpl_cnt_q + 8'd1;
        end
    end

    assign cmpl_cnt = cmpl_cnt_q;
`else
    assign cmpl_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_count_job_dispatcher.sv
// Bench for count_job_dispatcher: downstream counter model, ld_cnt scoreboard,
// table-driven job groups and hand-written full-FIFO / reset / wrap sequences.
module tb_count_job_dispatcher;
    localparam int unsigned NBITS = 3;
    localparam int unsigned DEPTH = 4;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic             req_val = 1'b0;
    logic             req_rdy;
    logic [NBITS-1:0] req_cnt = '0;
    logic             ld;
    logic [NBITS-1:0] ld_cnt;
    logic             done;
    logic             cmpl;
    logic             busy;
    logic [7:0]       cmpl_cnt;

    logic [NBITS-1:0] ctr_q;
    int               cyc = 0;
    int               n_chk = 0;
    int               n_pass = 0;
    int               exp_cmpl_cnt = 0;
    int               ld_log[$];
    int               cmpl_log[$];
    int               busy_log[$];
    logic [NBITS-1:0] exp_q[$];

    typedef struct {
        int grp;
        int cnt;
        int ld_off;
        int cmpl_off;
    } vec_t;
    vec_t vecs[8];

    count_job_dispatcher #(.NBITS(NBITS), .DEPTH(DEPTH)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .req_val  (req_val),
        .req_rdy  (req_rdy),
        .req_cnt  (req_cnt),
        .ld       (ld),
        .ld_cnt   (ld_cnt),
        .done     (done),
        .cmpl     (cmpl),
        .busy     (busy),
        .cmpl_cnt (cmpl_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Downstream 3-bit loadable down-counter
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) ctr_q <= '0;
        else if (ld) ctr_q <= ld_cnt;
        else if (ctr_q != '0) ctr_q <= ctr_q - NBITS'(1);
    end
    assign done = (ctr_q == '0);

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    // Monitor: ld_cnt scoreboard, event logs and cmpl_cnt model
    always @(negedge clk) begin
        if (!reset_n) exp_cmpl_cnt = 0;
        if (ld) begin
            if (exp_q.size() == 0) check("ld_unexpected", 1, 0);
            else check("ld_cnt", int'(ld_cnt), int'(exp_q.pop_front()));
            ld_log.push_back(cyc);
        end else begin
            check("ld_cnt_idle", int'(ld_cnt), 0);
        end
        if (cmpl) cmpl_log.push_back(cyc);
        if (busy) busy_log.push_back(cyc);
        check("cmpl_cnt", int'(cmpl_cnt), exp_cmpl_cnt);
`ifdef COUNT_JOB_DISPATCHER_CMPL_CNT_EN
        if (cmpl) exp_cmpl_cnt = (exp_cmpl_cnt + 1) % 256;
`endif
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        ld_log.delete();
        cmpl_log.delete();
        busy_log.delete();
    endtask

    task automatic wait_drain(input int budget);
        int b;
        b = 0;
        while (!(busy == 1'b0 && exp_q.size() == 0) && b < budget) begin
            step();
            b++;
        end
        check("drain_in_budget", int'(b < budget), 1);
    endtask

    task automatic run_group(input int g);
        int idx[$];
        int t0;
        int first;
        int last;
        foreach (vecs[i]) if (vecs[i].grp == g) idx.push_back(i);
        clear_logs();
        t0 = cyc;
        foreach (idx[j]) begin
            req_val = 1'b1;
            req_cnt = NBITS'(vecs[idx[j]].cnt);
            check("enq_rdy", int'(req_rdy), 1);
            exp_q.push_back(NBITS'(vecs[idx[j]].cnt));
            step();
        end
        req_val = 1'b0;
        wait_drain(200);
        check("n_ld", ld_log.size(), idx.size());
        check("n_cmpl", cmpl_log.size(), idx.size());
        foreach (idx[j]) begin
            if (j < ld_log.size()) check("ld_cycle", ld_log[j] - t0, vecs[idx[j]].ld_off);
            if (j < cmpl_log.size()) check("cmpl_cycle", cmpl_log[j] - t0, vecs[idx[j]].cmpl_off);
        end
        first = vecs[idx[0]].ld_off;
        last  = vecs[idx[idx.size()-1]].cmpl_off;
        check("busy_len", busy_log.size(), last - first + 1);
        if (busy_log.size() > 0) begin
            check("busy_first", busy_log[0] - t0, first);
            check("busy_last", busy_log[busy_log.size()-1] - t0, last);
        end
    endtask

    initial begin
        int t0;
        int k;
        int b;
        int sent;
        bit saw_full;
        bit prev_ld;
        int data[5];

        vecs[0] = '{0, 3, 2, 6};
        vecs[1] = '{1, 2, 2, 5};
        vecs[2] = '{1, 0, 6, 7};
        vecs[3] = '{1, 1, 8, 10};
        vecs[4] = '{2, 5, 2, 8};
        vecs[5] = '{2, 7, 9, 17};
        vecs[6] = '{3, 0, 2, 3};
        vecs[7] = '{4, 7, 2, 10};

        // Reset state and quiet idle
        step(); step(); step();
        check("rst_ld", int'(ld), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_rdy", int'(req_rdy), 1);
        check("rst_cmpl", int'(cmpl), 0);
        check("rst_cmpl_cnt", int'(cmpl_cnt), 0);
        reset_n = 1'b1;
        clear_logs();
        for (int i = 0; i < 10; i++) step();
        check("idle_no_ld", ld_log.size(), 0);
        check("idle_busy", int'(busy), 0);

        for (int g = 0; g < 5; g++) run_group(g);

        // Single job, cycle by cycle against the counter
        t0 = cyc;
        req_val = 1'b1;
        req_cnt = NBITS'(3);
        exp_q.push_back(NBITS'(3));
        step();
        req_val = 1'b0;
        while (cyc - t0 <= 7) begin
            if (cyc - t0 >= 3 && cyc - t0 <= 6) check("ctr_val", int'(ctr_q), 6 - (cyc - t0));
            check("single_ld", int'(ld), int'(cyc - t0 == 2));
            check("single_cmpl", int'(cmpl), int'(cyc - t0 == 6));
            step();
        end
        check("single_idle", int'(busy), 0);

        // Full FIFO behind a long job
        clear_logs();
        req_val = 1'b1;
        req_cnt = NBITS'(7);
        exp_q.push_back(NBITS'(7));
        step();
        req_val = 1'b0;
        b = 0;
        while (!ld && b < 10) begin
            step();
            b++;
        end
        check("full_first_ld", int'(ld), 1);
        step();
        data = '{1, 2, 3, 4, 5};
        k = 0;
        saw_full = 1'b0;
        prev_ld = 1'b0;
        for (int i = 0; i < 40 && k < 5; i++) begin
            req_val = 1'b1;
            req_cnt = NBITS'(data[k]);
            if (k == 4 && !saw_full) begin
                check("full_rdy", int'(req_rdy), 0);
                check("full_after_4", i, 4);
                saw_full = 1'b1;
            end
            if (k == 4 && ld) check("no_passthru_rdy", int'(req_rdy), 0);
            if (prev_ld) check("rdy_after_pop", int'(req_rdy), 1);
            if (req_rdy) begin
                exp_q.push_back(NBITS'(data[k]));
                k++;
            end
            prev_ld = ld;
            step();
        end
        req_val = 1'b0;
        check("full_accepted", k, 5);
        wait_drain(200);
        check("full_n_ld", ld_log.size(), 6);

        // Reset in the middle of a run, on a done cycle
        clear_logs();
        for (int i = 0; i < 3; i++) begin
            req_val = 1'b1;
            req_cnt = NBITS'(i == 0 ? 2 : 3);
            exp_q.push_back(NBITS'(i == 0 ? 2 : 3));
            step();
        end
        req_val = 1'b0;
        b = 0;
        while (!cmpl && b < 20) begin
            step();
            b++;
        end
        check("pre_rst_cmpl", int'(cmpl), 1);
        reset_n = 1'b0;
        #1;
        check("mid_rst_busy", int'(busy), 0);
        check("mid_rst_cmpl", int'(cmpl), 0);
        check("mid_rst_ld", int'(ld), 0);
        check("mid_rst_rdy", int'(req_rdy), 1);
        exp_q.delete();
        step(); step();
        reset_n = 1'b1;
        clear_logs();
        for (int i = 0; i < 12; i++) step();
        check("post_rst_no_ld", ld_log.size(), 0);
        check("post_rst_no_cmpl", cmpl_log.size(), 0);
        check("post_rst_busy", int'(busy), 0);

        // 257 zero-count jobs through the completion counter
        clear_logs();
        sent = 0;
        for (int i = 0; i < 3000 && sent < 257; i++) begin
            req_val = 1'b1;
            req_cnt = '0;
            if (req_rdy) begin
                exp_q.push_back('0);
                sent++;
            end
            step();
        end
        req_val = 1'b0;
        check("zero_sent", sent, 257);
        wait_drain(100);
        check("zero_n_cmpl", cmpl_log.size(), 257);
        check("zero_n_ld", ld_log.size(), 257);
`ifdef COUNT_JOB_DISPATCHER_CMPL_CNT_EN
        check("cmpl_cnt_wrap", int'(cmpl_cnt), 1);
`else
        check("cmpl_cnt_tied", int'(cmpl_cnt), 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
